// File: rtl/add_round_key.sv
// AES-128 AddRoundKey: bitwise XOR of the cipher state with the round key,
// behind a valid/ready interface with an optional two-entry skid-buffer output stage.
module add_round_key #(
    parameter int REG_OUT = 1,
    parameter int WIDTH   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] state_in,
    input  logic [WIDTH-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] state_out
);

    logic [WIDTH-1:0] w_xor;

    assign w_xor = state_in ^ key_in;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] r_main_data;
            logic [WIDTH-1:0] r_skid_data;
            logic             r_main_valid;
            logic             r_skid_valid;
            logic             r_in_ready;
            logic             w_in_fire;
            logic             w_main_free;

            assign w_in_fire   = in_valid & r_in_ready;
            // Main register can take new data when empty or being drained this cycle.
            assign w_main_free = ~r_main_valid | out_ready;

            // Two-entry skid buffer; the skid entry only fills while main is stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main_data  <= {WIDTH{1'b0}};
                    r_skid_data  <= {WIDTH{1'b0}};
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b0;
                end else if (w_main_free) begin
                    if (r_skid_valid) begin
                        r_main_data  <= r_skid_data;
                        r_main_valid <= 1'b1;
                        r_skid_valid <= 1'b0;
                    end else if (w_in_fire) begin
                        r_main_data  <= w_xor;
                        r_main_valid <= 1'b1;
                    end else begin
                        r_main_valid <= 1'b0;
                    end
                    r_in_ready <= 1'b1;
                end else if (w_in_fire) begin
                    r_skid_data  <= w_xor;
                    r_skid_valid <= 1'b1;
                    r_in_ready   <= 1'b0;
                end else begin
                    r_skid_valid <= r_skid_valid;
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = r_main_valid;
            assign state_out = r_main_data;
        end else begin : g_comb
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign state_out = w_xor;
        end
    endgenerate

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key (REG_OUT=1): random traffic against a
// queue-based FIFO reference of the accepted XOR results.
module tb_add_round_key;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    logic [127:0] want_q[$];
    int           spur;
    int           n_cmp;
    int           n_err;

    add_round_key #(.REG_OUT(1), .WIDTH(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: observe transfers at the negedge, update the reference, end #1 after posedge.
    task automatic step(output logic acc);
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    spur++;
                end else begin
                    got_q.push_back(state_out);
                    want_q.push_back(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(state_in ^ key_in);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic a;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        state_in = rand128(); key_in = rand128();
        step(a);
        step(a);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || state_out !== 128'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%b d=%h expected v=0 r=0 d=0", out_valid, in_ready, state_out);
        end
        rst = 1'b0; in_valid = 1'b0;
        step(a);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
        end
        state_in = 128'd0; key_in = 128'd0; in_valid = 1'b1;
        step(a);
        in_valid = 1'b0;
        n_cmp++;
        if (a !== 1'b1 || out_valid !== 1'b1 || state_out !== 128'd0) begin
            n_err++;
            $display("FAIL idle_zero: got acc=%b v=%b d=%h expected acc=1 v=1 d=0", a, out_valid, state_out);
        end
        step(a);
        n_cmp++;
        if (got_q.size() != 1 || spur != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_drain: got outs=%0d spur=%0d v=%b expected outs=1 spur=0 v=0", got_q.size(), spur, out_valid);
        end
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_known_vector();
        logic         a;
        logic [127:0] ref_v;
        ref_v = 128'h657470750fc7ff3fc0e8e8ca4dd02a9c;
        state_in = 128'hb9e447c5948e20d657169af575513f3b;
        key_in   = 128'hdc9037b09b49dfe997fe723f388115a7;
        in_valid = 1'b1; out_ready = 1'b1;
        step(a);
        in_valid = 1'b0;
        n_cmp++;
        if (a !== 1'b1 || out_valid !== 1'b1 || state_out !== ref_v) begin
            n_err++;
            $display("FAIL known_vector: got acc=%b v=%b d=%h expected acc=1 v=1 d=%h", a, out_valid, state_out, ref_v);
        end
        step(a);
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_identity();
        logic         a;
        logic [127:0] s;
        logic [127:0] e;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            s = rand128();
            state_in = s;
            if (j == 0) begin
                key_in = 128'd0; e = s;
            end else if (j == 1) begin
                key_in = {128{1'b1}}; e = ~s;
            end else begin
                key_in = s; e = 128'd0;
            end
            in_valid = 1'b1;
            step(a);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || state_out !== e) begin
                n_err++;
                $display("FAIL identity_%0d: got v=%b d=%h expected v=1 d=%h", j, out_valid, state_out, e);
            end
            step(a);
        end
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_back_pressure();
        logic         a;
        logic [127:0] vs[4];
        logic [127:0] vk[4];
        int           idx;
        logic         saw_block;
        idx = 0; saw_block = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vs[i] = rand128(); vk[i] = rand128();
        end
        for (int c = 0; c < 30 && (idx < 4 || exp_q.size() > 0); c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (idx < 4);
            state_in  = vs[idx % 4];
            key_in    = vk[idx % 4];
            step(a);
            if (a) idx++;
            if (in_ready === 1'b0) saw_block = 1'b1;
            n_cmp++;
            if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0) ||
                (exp_q.size() > 0 && state_out !== exp_q[0])) begin
                n_err++;
                $display("FAIL bp_cycle_%0d: got r=%b v=%b d=%h expected r=%b v=%b d=%h", c, in_ready, out_valid,
                         state_out, exp_q.size() < 2, exp_q.size() > 0, (exp_q.size() > 0) ? exp_q[0] : 128'd0);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (saw_block !== 1'b1 || got_q.size() != 4 || spur != 0) begin
            n_err++;
            $display("FAIL bp_summary: got block=%b outs=%0d spur=%0d expected block=1 outs=4 spur=0", saw_block, got_q.size(), spur);
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_cmp++;
            if (got_q[i] !== (vs[i] ^ vk[i])) begin
                n_err++;
                $display("FAIL bp_order_%0d: got %h expected %h", i, got_q[i], vs[i] ^ vk[i]);
            end
        end
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_throughput();
        logic a;
        int   n_acc;
        int   n_gap;
        n_acc = 0; n_gap = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            state_in = rand128(); key_in = rand128(); in_valid = 1'b1;
            step(a);
            if (a) n_acc++;
            if (out_valid !== 1'b1) n_gap++;
        end
        in_valid = 1'b0;
        step(a);
        n_cmp++;
        if (n_acc != 100 || n_gap != 0 || got_q.size() != 100 || spur != 0) begin
            n_err++;
            $display("FAIL throughput: got acc=%0d gaps=%0d outs=%0d spur=%0d expected 100/0/100/0", n_acc, n_gap, got_q.size(), spur);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== want_q[i]) begin
                n_err++;
                $display("FAIL throughput_data_%0d: got %h expected %h", i, got_q[i], want_q[i]);
            end
        end
        got_q.delete(); want_q.delete();
    endtask

    task automatic test_reset_mid_stream();
        logic         a;
        logic [127:0] s;
        logic [127:0] k;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5 && exp_q.size() < 2; i++) begin
            state_in = rand128(); key_in = rand128();
            step(a);
        end
        n_cmp++;
        if (exp_q.size() != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_fill: got held=%0d r=%b v=%b expected held=2 r=0 v=1", exp_q.size(), in_ready, out_valid);
        end
        rst = 1'b1;
        step(a);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || state_out !== 128'd0) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b r=%b d=%h expected v=0 r=0 d=0", out_valid, in_ready, state_out);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(a);
        n_cmp++;
        if (got_q.size() != 0 || spur != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_stale: got outs=%0d spur=%0d v=%b r=%b expected 0/0/0/1", got_q.size(), spur, out_valid, in_ready);
        end
        s = rand128(); k = rand128();
        state_in = s; key_in = k; in_valid = 1'b1;
        step(a);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(a);
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 0 || (got_q.size() == 1 && got_q[0] !== (s ^ k))) begin
            n_err++;
            $display("FAIL rst_recover: got outs=%0d d=%h expected outs=1 d=%h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 128'd0, s ^ k);
        end
        got_q.delete(); want_q.delete();
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        state_in = 128'd0; key_in = 128'd0;
        spur = 0; n_cmp = 0; n_err = 0;
        test_reset();
        test_known_vector();
        test_identity();
        test_back_pressure();
        test_throughput();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
AES-128 AddRoundKey stage. It computes the bitwise XOR of a 128-bit cipher state with a 128-bit round key. The block sits between MixColumns (or the input whitening step) and the next round in the AES datapath. It is wrapped in a valid/ready streaming interface with a registered, full-throughput skid-buffer output stage so it can be chained in a pipelined cipher core.

Parameters:
- REG_OUT, default 1. 1 = registered output through a 2-entry skid buffer. 0 = purely combinational pass-through, where clk and rst are unused.
- WIDTH, default 128. State and key width in bits. Must be a multiple of 8; only 128 is supported for AES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in and key_in are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- state_in  input  WIDTH  AES state; byte 0 = bits [127:120], column-major order.
- key_in  input  WIDTH  round key, same byte order as state_in.
- out_valid  output  1  state_out is valid.
- out_ready  input  1  downstream accepts state_out this cycle.
- state_out  output  WIDTH  state_in XOR key_in.

Behaviour:
- Function: state_out[i] = state_in[i] ^ key_in[i] for all bits. There is no byte reordering; byte lanes are independent.
- Transfer rules:
  - An input transfer occurs on a rising edge where in_valid && in_ready.
  - An output transfer occurs on a rising edge where out_valid && out_ready.
- REG_OUT=1, latency: the result is presented on state_out one cycle after the input transfer.
- REG_OUT=1, throughput: one transfer per cycle is sustained while out_ready=1.
- Skid buffer: main register plus a skid register; in_ready is driven from a flop.
  - in_ready = 1 whenever the skid register is empty.
  - Input accepted while the main register holds untaken data (out_valid && !out_ready): the result goes to the skid register, and in_ready drops the next cycle.
  - When the main data is taken: the skid content moves to main, and in_ready rises the next cycle.
  - Simultaneous accept and take with the skid empty: main is replaced by the new result, out_valid stays 1, and there is no bubble.
  - Ordering is strictly FIFO. There is no data loss or duplication.
- Stall stability: while out_valid=1 and out_ready=0, state_out and out_valid must hold stable.
- Reset values (REG_OUT=1), on a cycle with rst=1:
  - out_valid=0.
  - in_ready=0 during reset, then 1 in the first cycle after rst deasserts.
  - Both buffer entries empty.
  - state_out data registers cleared to 0.
- Reset mid-operation: in-flight data is discarded, and no output transfer is reported after the reset edge.
- Inputs are don't-care when in_valid=0. The data registers load only on an accepted transfer, so there is no X propagation into held data.
- REG_OUT=0:
  - state_out = state_in ^ key_in combinationally.
  - out_valid = in_valid.
  - in_ready = out_ready.
  - No state.

Test Plan:
- Reset/idle: state_in=0, key_in=0, in_valid=1, out_ready=1 -> state_out=0 with out_valid=1 one cycle later. During rst: out_valid=0, in_ready=0.
- Known vector: state_in=b9e447c5948e20d657169af575513f3b, key_in=dc9037b09b49dfe997fe723f388115a7 -> state_out=65747075 0fc7ff3f c0e8e8ca 4dd02a9c, one cycle after acceptance.
- Identity/inversion: key_in=0 -> state_out=state_in. key_in=all-ones -> state_out=~state_in. Also state_in=key_in -> 0.
- Back-pressure: stream 4 random vectors back-to-back with out_ready held 0 for 3 cycles mid-stream. Required response:
  - in_ready deasserts after the skid fills.
  - state_out is held stable during the stall.
  - All 4 results are delivered in order with none lost.
- Full throughput: in_valid=1 and out_ready=1 for 100 random vectors -> one result per cycle with no bubbles; all results match a reference XOR.
- Reset mid-stream: assert rst with both buffer entries full -> out_valid=0 the next cycle, and no stale outputs appear after rst deasserts.
